// File: rtl/mem_burst_pkg.sv
// Shared types and helpers for the line-to-word burst master.
// Holds the burst FSM encoding and the line base address helper.
package mem_burst_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        DONE
    } burst_state_t;

    localparam int WORD_W = 16;
    localparam int ADDR_W = 16;
    localparam logic [1:0] WORD_MASK_FULL = 2'b11;

    // Clears the byte offset inside a line of `words` 16-bit words.
    function automatic logic [ADDR_W-1:0] line_base(
        input logic [ADDR_W-1:0] addr,
        input int                words
    );
        logic [ADDR_W-1:0] mask;
        mask = ADDR_W'(2 * words - 1);
        return addr & ~mask;
    endfunction

endpackage

// File: rtl/line_burst_master.sv
// Splits one cache-line fill/evict into sequential 16-bit word beats.
// All memory-side outputs are registered; nothing upstream reaches them combinationally.
module line_burst_master
    import mem_burst_pkg::*;
#(
    parameter int WORDS_PER_LINE = 8,
    localparam int LINE_W = WORD_W * WORDS_PER_LINE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              line_read,
    input  logic              line_write,
    input  logic [15:0]       line_addr,
    input  logic [LINE_W-1:0] line_wdata,
    output logic              line_resp,
    output logic [LINE_W-1:0] line_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [1:0]        mem_wmask,
    output logic [15:0]       mem_address,
    output logic [15:0]       mem_wdata,
    input  logic              mem_resp,
    input  logic [15:0]       mem_rdata
);

    localparam int CNT_W = $clog2(WORDS_PER_LINE);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS_PER_LINE - 1);

    burst_state_t                           state_q;
    logic [CNT_W-1:0]                       cnt_q;
    logic [15:0]                            addr_q;
    logic [15:0]                            wdata_q;
    logic                                   rd_q;
    logic                                   wr_q;
    logic                                   resp_q;
    logic [WORDS_PER_LINE-1:0][WORD_W-1:0]  wbuf_q;
    logic [WORDS_PER_LINE-1:0][WORD_W-1:0]  rdata_q;

    logic [15:0]      base_d;
    logic [15:0]      addr_d;
    logic [CNT_W-1:0] cnt_d;
    logic             last_d;

    always_comb begin
        base_d = line_base(line_addr, WORDS_PER_LINE);
        addr_d = addr_q + 16'd2;
        cnt_d  = cnt_q + 1'b1;
        last_d = (cnt_q == LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            resp_q  <= 1'b0;
            wbuf_q  <= '0;
            rdata_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    // Write wins when both requests arrive together.
                    if (line_write) begin
                        state_q <= WR;
                        wr_q    <= 1'b1;
                        addr_q  <= base_d;
                        cnt_q   <= '0;
                        wbuf_q  <= line_wdata;
                        wdata_q <= line_wdata[WORD_W-1:0];
                    end else if (line_read) begin
                        state_q <= RD;
                        rd_q    <= 1'b1;
                        addr_q  <= base_d;
                        cnt_q   <= '0;
                    end
                end
                RD: begin
                    if (mem_resp) begin
                        rdata_q[cnt_q] <= mem_rdata;
                        if (last_d) begin
                            state_q <= DONE;
                            rd_q    <= 1'b0;
                            resp_q  <= 1'b1;
                            addr_q  <= '0;
                        end else begin
                            cnt_q  <= cnt_d;
                            addr_q <= addr_d;
                        end
                    end
                end
                WR: begin
                    if (mem_resp) begin
                        if (last_d) begin
                            state_q <= DONE;
                            wr_q    <= 1'b0;
                            resp_q  <= 1'b1;
                            addr_q  <= '0;
                            wdata_q <= '0;
                        end else begin
                            cnt_q   <= cnt_d;
                            addr_q  <= addr_d;
                            wdata_q <= wbuf_q[cnt_d];
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    resp_q  <= 1'b0;
                    cnt_q   <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_read    = rd_q;
    assign mem_write   = wr_q;
    assign mem_wmask   = wr_q ? WORD_MASK_FULL : 2'b00;
    assign mem_address = addr_q;
    assign mem_wdata   = wdata_q;
    assign line_resp   = resp_q;
    assign line_rdata  = rdata_q;

endmodule

// File: tb/tb_line_burst_master.sv
// Randomized bench for line_burst_master against a transaction-level line model.
// The harness memory starts with word at byte address A equal to A.
module tb_line_burst_master;

    logic              clk = 1'b0;
    logic              rst;
    logic              line_read;
    logic              line_write;
    logic [15:0]       line_addr;
    logic [127:0]      line_wdata;
    logic              line_resp;
    logic [127:0]      line_rdata;
    logic              mem_read;
    logic              mem_write;
    logic [1:0]        mem_wmask;
    logic [15:0]       mem_address;
    logic [15:0]       mem_wdata;
    logic              mem_resp;
    logic [15:0]       mem_rdata;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    line_burst_master #(.WORDS_PER_LINE(8)) dut (
        .clk(clk), .rst(rst),
        .line_read(line_read), .line_write(line_write),
        .line_addr(line_addr), .line_wdata(line_wdata),
        .line_resp(line_resp), .line_rdata(line_rdata),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_wmask(mem_wmask), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_resp(mem_resp),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Harness memory with programmable wait cycles per beat
    logic [15:0] mem [32768];
    int waits = 0;
    int wc = 0;

    assign mem_resp  = (mem_read | mem_write) && (wc == waits);
    assign mem_rdata = mem[mem_address[15:1]];

    always @(posedge clk) begin
        if ((mem_read | mem_write) && !mem_resp) wc <= wc + 1;
        else wc <= 0;
        if (mem_write && mem_resp) mem[mem_address[15:1]] <= mem_wdata;
    end

    // Transaction-level reference model
    logic [15:0]      ref_mem [32768];
    bit               m_busy = 1'b0;
    bit               m_resp = 1'b0;
    bit               m_wr = 1'b0;
    int               m_beat = 0;
    logic [15:0]      m_base = '0;
    logic [7:0][15:0] m_wbuf = '0;
    logic [7:0][15:0] m_rdata = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy  <= 1'b0;
            m_resp  <= 1'b0;
            m_beat  <= 0;
            m_rdata <= '0;
        end else if (m_resp) begin
            m_resp <= 1'b0;
        end else if (m_busy) begin
            if (mem_resp) begin
                if (m_wr)
                    ref_mem[int'(m_base >> 1) + m_beat] <= m_wbuf[m_beat];
                else
                    m_rdata[m_beat] <= ref_mem[int'(m_base >> 1) + m_beat];
                if (m_beat == 7) begin
                    m_busy <= 1'b0;
                    m_resp <= 1'b1;
                end
                m_beat <= m_beat + 1;
            end
        end else if (line_write || line_read) begin
            m_busy <= 1'b1;
            m_wr   <= line_write;
            m_base <= line_addr - (line_addr % 16'd16);
            m_beat <= 0;
            m_wbuf <= line_wdata;
        end
    end

    task automatic check(input string nm, input logic [127:0] act,
                         input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", nm, act, exp);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (started) begin
            check("mem_read", mem_read, m_busy && !m_wr);
            check("mem_write", mem_write, m_busy && m_wr);
            check("line_resp", line_resp, m_resp);
            check("line_rdata", line_rdata, m_rdata);
            if (m_busy) begin
                check("mem_address", mem_address, m_base + 16'(2 * m_beat));
                if (m_wr) begin
                    check("mem_wdata", mem_wdata, m_wbuf[m_beat]);
                    check("mem_wmask", mem_wmask, 2'b11);
                end
            end
        end
    end

    int cyc;
    int reads_seen;
    int writes_seen;
    bit zero_seen;
    logic [15:0] first_addr;

    task automatic do_line(input bit rd, input bit wr, input logic [15:0] a,
                           input logic [127:0] wd, input int w, input bit jit);
        bit got;
        bit have_first;
        waits = w;
        @(posedge clk);
        #1;
        line_read  = rd;
        line_write = wr;
        line_addr  = a;
        line_wdata = wd;
        cyc = 0;
        reads_seen = 0;
        writes_seen = 0;
        zero_seen = 1'b0;
        first_addr = '0;
        got = 1'b0;
        have_first = 1'b0;
        while (!got && cyc < 400) begin
            @(posedge clk);
            cyc++;
            #1;
            if (jit && ($urandom % 2 == 0)) begin
                line_addr  = 16'($urandom);
                line_wdata = {$urandom, $urandom, $urandom, $urandom};
            end
            @(negedge clk);
            if ((mem_read | mem_write) && !have_first) begin
                first_addr = mem_address;
                have_first = 1'b1;
            end
            if ((mem_read | mem_write) && mem_address == 16'h0000)
                zero_seen = 1'b1;
            if (mem_read && mem_resp) reads_seen++;
            if (mem_write && mem_resp) writes_seen++;
            if (line_resp) got = 1'b1;
        end
        if (!got) begin
            errors++;
            $display("FAIL line_resp_timeout got 0 exp 1");
        end
        @(posedge clk);
        #1;
        line_read  = 1'b0;
        line_write = 1'b0;
    endtask

    logic [7:0][15:0] e;
    logic [127:0]     save;
    int               n;

    initial begin
        for (int i = 0; i < 32768; i++) begin
            mem[i]     = 16'(2 * i);
            ref_mem[i] = 16'(2 * i);
        end
        rst = 1'b1;
        line_read = 1'b0;
        line_write = 1'b0;
        line_addr = '0;
        line_wdata = '0;
        repeat (2) @(posedge clk);
        started = 1'b1;
        @(negedge clk);
        check("rst_mem_read", mem_read, 1'b0);
        check("rst_line_resp", line_resp, 1'b0);
        check("rst_rdata", line_rdata, '0);
        check("rst_addr", mem_address, 16'h0000);
        @(posedge clk);
        #1 rst = 1'b0;

        // Plain fill
        do_line(1'b1, 1'b0, 16'h0124, '0, 0, 1'b0);
        for (int i = 0; i < 8; i++) e[i] = 16'h0120 + 16'(2 * i);
        check("t1_latency", cyc, 9);
        check("t1_first", first_addr, 16'h0120);
        check("t1_beats", reads_seen, 8);
        check("t1_rdata", line_rdata, e);

        // Evict then read back
        for (int i = 0; i < 8; i++) e[i] = 16'(i);
        do_line(1'b0, 1'b1, 16'h0040, e, 0, 1'b0);
        check("t2_first", first_addr, 16'h0040);
        check("t2_beats", writes_seen, 8);
        do_line(1'b1, 1'b0, 16'h0046, '0, 0, 1'b0);
        check("t2_readback", line_rdata, e);

        // Two wait cycles per beat
        do_line(1'b1, 1'b0, 16'h0200, '0, 2, 1'b0);
        for (int i = 0; i < 8; i++) e[i] = 16'h0200 + 16'(2 * i);
        check("t3_latency", cyc, 25);
        check("t3_rdata", line_rdata, e);

        // Both requests high: write only
        save = line_rdata;
        do_line(1'b1, 1'b1, 16'h0080,
                {$urandom, $urandom, $urandom, $urandom}, 0, 1'b0);
        check("t4_reads", reads_seen, 0);
        check("t4_writes", writes_seen, 8);
        check("t4_rdata_hold", line_rdata, save);

        // Reset during beat 3 of a fill
        waits = 1;
        @(posedge clk);
        #1;
        line_read = 1'b1;
        line_addr = 16'h0500;
        n = 0;
        while (!(mem_read && mem_address == 16'h0506) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t5_reach_beat3", n < 50, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_read", mem_read, 1'b0);
        check("t5_rst_write", mem_write, 1'b0);
        check("t5_rst_resp", line_resp, 1'b0);
        check("t5_rst_rdata", line_rdata, '0);
        line_read = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        do_line(1'b1, 1'b0, 16'h0300, '0, 0, 1'b0);
        check("t5_first", first_addr, 16'h0300);
        check("t5_latency", cyc, 9);

        // Top line, no wrap
        do_line(1'b1, 1'b0, 16'hFFF6, '0, 0, 1'b0);
        check("t6_first", first_addr, 16'hFFF0);
        check("t6_no_zero", zero_seen, 1'b0);
        check("t6_last_word", line_rdata[127:112], 16'hFFFE);
        @(negedge clk);
        check("t6_idle_read", mem_read, 1'b0);
        check("t6_idle_resp", line_resp, 1'b0);

        // Random traffic with mid-burst input changes
        for (int t = 0; t < 60; t++) begin
            int k;
            logic [15:0] a;
            k = $urandom_range(0, 2);
            case ($urandom_range(0, 2))
                0: a = 16'h0100 + 16'($urandom_range(0, 63));
                1: a = 16'hFFF0 + 16'($urandom_range(0, 15));
                default: a = 16'($urandom);
            endcase
            do_line(k != 1, k != 0, a,
                    {$urandom, $urandom, $urandom, $urandom},
                    $urandom_range(0, 3), 1'b1);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
